register_file: RTL and testbench

- General-purpose register file for the 8-bit CPU datapath: 8 registers x 8 bits.
- One synchronous write port and two independent combinational read ports.
- Feeds the ALU operand buses (rd_data1/rd_data2); written back from the ALU/load path.

---
 rtl/register_file.sv | 38 +++
 tb/tb_register_file.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 8x8 general-purpose register file: one synchronous write port, two combinational read ports.
// Asynchronous active-low reset clears every register, R0 included.
module register_file #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic       clk;
    logic       rst_n;
    logic       write_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;

    int errors = 0;
    int checks = 0;

    register_file #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .write_en(write_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge so inputs are stable at the rising edge; sample #1 after it.
    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        write_en = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic read_both(input logic [2:0] a1, input logic [2:0] a2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        write_en = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        read_both(3'd0, 3'd7);
        check("reset_r0", rd_data1, 8'h00);
        check("reset_r7", rd_data2, 8'h00);
        // Writes during reset must be ignored.
        write_reg(3'd5, 8'hAB);
        read_both(3'd5, 3'd5);
        check("write_in_reset", rd_data1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic writes
        write_reg(3'd2, 8'd42);
        write_reg(3'd4, 8'd100);
        read_both(3'd2, 3'd4);
        check("basic_r2", rd_data1, 8'd42);
        check("basic_r4", rd_data2, 8'd100);

        // Write disable
        @(negedge clk);
        write_en = 1'b0;
        wr_addr  = 3'd4;
        wr_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("disable_r4", rd_data2, 8'd100);
        read_both(3'd2, 3'd1);
        check("unwritten_r1", rd_data2, 8'h00);

        // Same-address read/write: old value before the edge, new right after
        @(negedge clk);
        read_both(3'd3, 3'd3);
        write_en = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 8'h5A;
        #1;
        check("raw_before", rd_data1, 8'h00);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        check("raw_after_p1", rd_data1, 8'h5A);
        check("raw_after_p2", rd_data2, 8'h5A);

        // Full sweep
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 8'(8'h10 + i));
        end
        for (int i = 0; i < 8; i++) begin
            read_both(3'(i), 3'(7 - i));
            check($sformatf("sweep_p1_r%0d", i), rd_data1, 8'(8'h10 + i));
            check($sformatf("sweep_p2_r%0d", 7 - i), rd_data2, 8'(8'h10 + 7 - i));
        end
        read_both(3'd0, 3'd0);
        check("r0_writable", rd_data1, 8'h10);

        // Async reset mid-write, between edges
        @(negedge clk);
        write_en = 1'b1;
        wr_addr  = 3'd6;
        wr_data  = 8'hC3;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            read_both(3'(i), 3'(i));
            check($sformatf("async_rst_r%0d", i), rd_data1, 8'h00);
        end
        @(posedge clk);
        #1;
        read_both(3'd6, 3'd6);
        check("rst_overrides_write", rd_data2, 8'h00);
        @(negedge clk);
        rst_n    = 1'b1;
        write_en = 1'b0;
        write_reg(3'd6, 8'h77);
        read_both(3'd6, 3'd0);
        check("post_rst_write", rd_data1, 8'h77);
        check("post_rst_r0", rd_data2, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
